// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forwarding, load-use and MDU interlocks, stall counter
// Optional MDU busy interlock enabled by defining FU_MDU_INTERLOCK_EN.
module hazard_forward_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LAT     = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_mdu_start,
    input  logic                   id_hilo_read,
    input  logic [REG_ADDR_W-1:0]  ex_rs,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   mem_regwrite,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   wb_regwrite,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   stall,
    output logic                   bubble,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   lu_haz;
    logic                   mdu_haz;
    logic                   stall_raw;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // EX/MEM wins over MEM/WB; r0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (!rst) begin
            forward_a = fwd_sel(ex_rs);
            forward_b = fwd_sel(ex_rt);
        end
    end

    assign lu_haz = id_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

`ifdef FU_MDU_INTERLOCK_EN
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    localparam logic [7:0] MDU_LAT_C = 8'(MDU_LAT);

    mdu_state_t mdu_state_q;
    mdu_state_t mdu_state_d;
    logic [7:0] mdu_cnt_q;
    logic [7:0] mdu_cnt_d;
    logic       mdu_accept;

    assign mdu_busy   = (mdu_state_q == MDU_BUSY);
    assign mdu_haz    = id_valid && mdu_busy && (id_hilo_read || id_mdu_start);
    assign mdu_accept = id_valid && id_mdu_start && !stall_raw;

    always_comb begin
        mdu_state_d = mdu_state_q;
        mdu_cnt_d   = mdu_cnt_q;
        case (mdu_state_q)
            MDU_IDLE: begin
                if (mdu_accept) begin
                    mdu_cnt_d   = MDU_LAT_C;
                    mdu_state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                mdu_cnt_d = mdu_cnt_q - 8'd1;
                if (mdu_cnt_q <= 8'd1) begin
                    mdu_state_d = MDU_IDLE;
                end
            end
            default: begin
                mdu_state_d = MDU_IDLE;
                mdu_cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_state_q <= MDU_IDLE;
            mdu_cnt_q   <= 8'd0;
        end else begin
            mdu_state_q <= mdu_state_d;
            mdu_cnt_q   <= mdu_cnt_d;
        end
    end
`else
    logic unused_mdu_in;

    assign unused_mdu_in = id_mdu_start ^ id_hilo_read;
    assign mdu_busy      = 1'b0;
    assign mdu_haz       = 1'b0;
`endif

    assign stall_raw = !rst && (lu_haz || mdu_haz);
    assign stall     = stall_raw;
    assign bubble    = stall_raw;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_raw && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_mdu_start;
    logic          id_hilo_read;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [RW-1:0] ex_rd;
    logic          ex_mem_read;
    logic [RW-1:0] mem_rd;
    logic          mem_regwrite;
    logic [RW-1:0] wb_rd;
    logic          wb_regwrite;
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic          stall;
    logic          bubble;
    logic          mdu_busy;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_ADDR_W (RW),
        .MDU_LAT    (4),
        .STALL_CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_mdu_start(id_mdu_start),
        .id_hilo_read(id_hilo_read),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .mem_rd      (mem_rd),
        .mem_regwrite(mem_regwrite),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall       (stall),
        .bubble      (bubble),
        .mdu_busy    (mdu_busy),
        .stall_cnt   (stall_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        id_valid     = 1'b0;
        id_rs        = '0;
        id_rt        = '0;
        id_mdu_start = 1'b0;
        id_hilo_read = 1'b0;
        ex_rs        = '0;
        ex_rt        = '0;
        ex_rd        = '0;
        ex_mem_read  = 1'b0;
        mem_rd       = '0;
        mem_regwrite = 1'b0;
        wb_rd        = '0;
        wb_regwrite  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        mem_regwrite = 1'b1; mem_rd = 5'd9; ex_rs = 5'd9;
        id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7;
        tick(); tick();
        check_val("rst_fwd_a", 32'(forward_a), 32'd0);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_bubble", 32'(bubble), 32'd0);
        check_val("rst_cnt", 32'(stall_cnt), 32'd0);
        check_val("rst_busy", 32'(mdu_busy), 32'd0);

        rst = 1'b0;
        clear_in();
        mem_regwrite = 1'b1; mem_rd = 5'd9; ex_rs = 5'd9;
        wb_regwrite = 1'b1; wb_rd = 5'd9; ex_rt = 5'd5;
        #1;
        check_val("fwd_a_mem_prio", 32'(forward_a), 32'd2);
        check_val("fwd_b_none", 32'(forward_b), 32'd0);

        mem_rd = 5'd3; wb_rd = 5'd6; ex_rt = 5'd6; ex_rs = 5'd6;
        #1;
        check_val("fwd_b_wb", 32'(forward_b), 32'd1);
        check_val("fwd_a_wb", 32'(forward_a), 32'd1);

        wb_rd = 5'd0; ex_rt = 5'd0; ex_rs = 5'd0; mem_rd = 5'd0;
        #1;
        check_val("fwd_b_r0", 32'(forward_b), 32'd0);
        check_val("fwd_a_r0", 32'(forward_a), 32'd0);

        mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_rd = 5'd4; ex_rs = 5'd4;
        #1;
        check_val("fwd_a_nowrite", 32'(forward_a), 32'd0);

        clear_in();
        id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd2;
        #1;
        check_val("lu_stall", 32'(stall), 32'd1);
        check_val("lu_bubble", 32'(bubble), 32'd1);
        tick();
        check_val("lu_cnt1", 32'(stall_cnt), 32'd1);
        ex_mem_read = 1'b0; ex_rd = 5'd0; mem_rd = 5'd7; mem_regwrite = 1'b1;
        #1;
        check_val("lu_release", 32'(stall), 32'd0);
        tick();
        check_val("lu_cnt_hold", 32'(stall_cnt), 32'd1);
        mem_regwrite = 1'b0; mem_rd = 5'd0; wb_rd = 5'd7; wb_regwrite = 1'b1;
        ex_rt = 5'd7; id_rt = 5'd0;
        #1;
        check_val("lu_dep_fwd_b", 32'(forward_b), 32'd1);

        clear_in();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_valid = 1'b0;
        #1;
        check_val("lu_invalid", 32'(stall), 32'd0);
        tick();
        check_val("lu_invalid_cnt", 32'(stall_cnt), 32'd1);

        id_valid = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
        #1;
        check_val("lu_r0", 32'(stall), 32'd0);

        ex_rd = 5'd12; id_rs = 5'd12;
        #1;
        check_val("lu_rs", 32'(stall), 32'd1);
        repeat (20) tick();
        check_val("cnt_saturate", 32'(stall_cnt), 32'd15);
        check_val("sat_stall_held", 32'(stall), 32'd1);

        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
        #1;
        check_val("cnt_cleared", 32'(stall_cnt), 32'd0);

`ifdef FU_MDU_INTERLOCK_EN
        id_valid = 1'b1; id_mdu_start = 1'b1;
        #1;
        check_val("mdu_c0_stall", 32'(stall), 32'd0);
        check_val("mdu_c0_busy", 32'(mdu_busy), 32'd0);
        tick();
        id_mdu_start = 1'b0; id_hilo_read = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check_val($sformatf("mdu_busy_c%0d", c), 32'(mdu_busy), 32'd1);
            check_val($sformatf("mdu_stall_c%0d", c), 32'(stall), 32'd1);
            tick();
        end
        #1;
        check_val("mdu_c5_busy", 32'(mdu_busy), 32'd0);
        check_val("mdu_c5_stall", 32'(stall), 32'd0);
        check_val("mdu_c5_cnt", 32'(stall_cnt), 32'd4);
        tick();

        id_hilo_read = 1'b0; id_mdu_start = 1'b1;
        #1;
        check_val("b2b_first", 32'(stall), 32'd0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            #1;
            check_val($sformatf("b2b_stall_c%0d", c), 32'(stall), 32'd1);
            tick();
        end
        #1;
        check_val("b2b_accept", 32'(stall), 32'd0);
        tick();
        id_mdu_start = 1'b0;
        #1;
        check_val("b2b_reload", 32'(mdu_busy), 32'd1);
        tick(); tick();
        check_val("mid_busy", 32'(mdu_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        #1;
        check_val("mid_rst_busy", 32'(mdu_busy), 32'd0);
        check_val("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        check_val("mid_rst_stall", 32'(stall), 32'd0);

        id_valid = 1'b1; id_mdu_start = 1'b1;
        tick();
        id_valid = 1'b0; id_mdu_start = 1'b0; id_hilo_read = 1'b1;
        #1;
        check_val("inv_no_stall", 32'(stall), 32'd0);
        repeat (4) tick();
        id_valid = 1'b1;
        #1;
        check_val("inv_decayed_busy", 32'(mdu_busy), 32'd0);
        check_val("inv_decayed_stall", 32'(stall), 32'd0);
`else
        id_valid = 1'b1; id_mdu_start = 1'b1; id_hilo_read = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val($sformatf("nomdu_stall_c%0d", c), 32'(stall), 32'd0);
            check_val($sformatf("nomdu_busy_c%0d", c), 32'(mdu_busy), 32'd0);
            tick();
        end
        check_val("nomdu_cnt", 32'(stall_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
